pc_sequencer: RTL

Multi-cycle instruction sequencer for the single-cycle-derived datapath: walks each instruction through IF/ID/EXE/MEM/WB, handshakes with instruction and data memory, and decides when and with what value the PC register is written. It sits beside the PC register, driving that register's `PCWre`, `PCData` and active-low `Reset` inputs, and gates the IR and register-file write enables. It also keeps a retired-instruction counter.

---
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle IF/ID/EXE/MEM/WB sequencer
// that owns PC write timing, next-PC selection and retire count.
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic [31:0] Imm,
  input  logic [25:0] Target,
  input  logic [31:0] RegRs,
  input  logic [31:0] PC,
  input  logic        IMemAck,
  input  logic        DMemAck,
  output logic        PCRst_n,
  output logic        PCWre,
  output logic [31:0] PCData,
  output logic        IMemReq,
  output logic        DMemReq,
  output logic        IRWre,
  output logic        RegWre,
  output logic [2:0]  State,
  output logic        Halted,
  output logic [31:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;

  logic is_r, is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jr, is_halt;

  // opcode class decode
  always_comb begin
    is_r    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    is_halt = 1'b0;
    unique case (Opcode)
      6'b000000: is_r    = 1'b1;
      6'b100011: is_lw   = 1'b1;
      6'b101011: is_sw   = 1'b1;
      6'b000100: is_beq  = 1'b1;
      6'b000101: is_bne  = 1'b1;
      6'b000010: is_j    = 1'b1;
      6'b111000: is_jr   = 1'b1;
      6'b111111: is_halt = 1'b1;
      default: ;
    endcase
  end

  logic        final_c;
  logic        taken;
  logic [31:0] pc4;

  assign pc4   = PC + 32'd4;
  assign taken = (is_beq & Zero) | (is_bne & ~Zero);

  // next-state and final-cycle detection
  always_comb begin
    state_d = state_q;
    final_c = 1'b0;
    unique case (state_q)
      S_IF: begin
        if (IMemAck) state_d = S_ID;
      end
      S_ID: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_r | is_lw | is_sw | is_beq | is_bne) begin
          state_d = S_EXE;
        end else begin
          final_c = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXE: begin
        if (is_r) begin
          state_d = S_WB;
        end else if (is_lw | is_sw) begin
          state_d = S_MEM;
        end else begin
          final_c = 1'b1;
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (DMemAck) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            final_c = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        final_c = 1'b1;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    if (Reset) state_d = S_IF;
  end

  // retire counter steps on each PC write
  always_comb begin
    count_d = count_q;
    if (Reset)        count_d = 32'd0;
    else if (final_c) count_d = count_q + 32'd1;
  end

  // next-PC selection; only differs from PC4 in a final cycle
  always_comb begin
    PCData = pc4;
    if (Reset) begin
      PCData = RESET_ADDR;
    end else if (final_c) begin
      if (state_q == S_EXE && taken)
        PCData = pc4 + (Imm << 2);
      else if (state_q == S_ID && is_j)
        PCData = {pc4[31:28], Target, 2'b00};
      else if (state_q == S_ID && is_jr)
        PCData = RegRs;
    end
  end

  // state and counter registers
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    count_q <= count_d;
  end

  assign PCRst_n    = ~Reset;
  assign PCWre      = ~Reset & final_c;
  assign IMemReq    = ~Reset & (state_q == S_IF);
  assign IRWre      = ~Reset & (state_q == S_IF) & IMemAck;
  assign DMemReq    = ~Reset & (state_q == S_MEM);
  assign RegWre     = ~Reset & (state_q == S_WB);
  assign State      = state_q;
  assign Halted     = (state_q == S_HALT);
  assign InstrCount = count_q;

endmodule
